// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the seq_det_param serial pattern detector.
// Optional build macro used by the detector: SEQ_DET_MASK_EN.
package seq_det_pkg;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } state_e;

    localparam int unsigned PAT_LEN_MAX = 16;

    // Ceiling log2; clog2(PAT_LEN+1) sizes a counter able to hold PAT_LEN itself.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_det_satcnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module seq_det_satcnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_det_param.sv
// Runtime-loadable serial bit-sequence detector with overlap control and match counter.
// Define SEQ_DET_MASK_EN to enable the per-bit don't-care mask.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_LEN = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_load,
    input  logic [PAT_LEN-1:0] cfg_pat,
    input  logic               cfg_ovl,
    input  logic [PAT_LEN-1:0] cfg_mask,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               armed
);

    localparam int unsigned        FILL_W = clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0]  FULL   = FILL_W'(PAT_LEN);

    state_e               state_q, state_d;
    logic [PAT_LEN-1:0]   hist_q, hist_d;
    logic [PAT_LEN-1:0]   pat_q, pat_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic                 ovl_q, ovl_d;
    logic                 match_q, match_d;
    logic                 pat_eq;

`ifdef SEQ_DET_MASK_EN
    logic [PAT_LEN-1:0]   mask_q, mask_d;
`else
    logic                 unused_mask;
    assign unused_mask = ^cfg_mask;
`endif

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        pat_d   = pat_q;
        fill_d  = fill_q;
        ovl_d   = ovl_q;
        match_d = 1'b0;
        pat_eq  = 1'b0;
`ifdef SEQ_DET_MASK_EN
        mask_d  = mask_q;
`endif
        if (cfg_load) begin
            pat_d   = cfg_pat;
            ovl_d   = cfg_ovl;
            hist_d  = '0;
            fill_d  = '0;
            state_d = ST_FILL;
`ifdef SEQ_DET_MASK_EN
            mask_d  = cfg_mask;
`endif
        end else if (in_valid) begin
            hist_d = {hist_q[PAT_LEN-2:0], in_bit};
            fill_d = (fill_q == FULL) ? FULL : fill_q + FILL_W'(1);
`ifdef SEQ_DET_MASK_EN
            pat_eq = ((hist_d ^ pat_q) & ~mask_q) == '0;
`else
            pat_eq = (hist_d == pat_q);
`endif
            match_d = pat_eq && (fill_d == FULL);
            case (state_q)
                ST_FILL:  if (fill_d == FULL) state_d = ST_ARMED;
                ST_ARMED: state_d = ST_ARMED;
                default:  state_d = ST_FILL;
            endcase
            // Non-overlap keeps the history bits but demands a full fresh window.
            if (match_d && !ovl_q) begin
                fill_d  = '0;
                state_d = ST_FILL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            hist_q  <= '0;
            pat_q   <= '0;
            fill_q  <= '0;
            ovl_q   <= 1'b1;
            match_q <= 1'b0;
`ifdef SEQ_DET_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            fill_q  <= fill_d;
            ovl_q   <= ovl_d;
            match_q <= match_d;
`ifdef SEQ_DET_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    seq_det_satcnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (match_d),
        .clr_i (cnt_clr),
        .cnt_o (match_cnt)
    );

    assign match = match_q;
    assign armed = (state_q == ST_ARMED);

endmodule

// File: tb/tb_seq_det_param.sv
// Self-checking bench for seq_det_param: queue-based reference model plus directed literals.
// Honours SEQ_DET_MASK_EN the same way the design does.
module tb_seq_det_param;

    localparam int unsigned PL      = 4;
    localparam int unsigned CW      = 2;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_load;
    logic [PL-1:0] cfg_pat;
    logic          cfg_ovl;
    logic [PL-1:0] cfg_mask;
    logic          in_valid;
    logic          in_bit;
    logic          cnt_clr;
    logic          match;
    logic [CW-1:0] match_cnt;
    logic          armed;

    int n_checks = 0;
    int n_errors = 0;

    seq_det_param #(
        .PAT_LEN(PL),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_load  (cfg_load),
        .cfg_pat   (cfg_pat),
        .cfg_ovl   (cfg_ovl),
        .cfg_mask  (cfg_mask),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .cnt_clr   (cnt_clr),
        .match     (match),
        .match_cnt (match_cnt),
        .armed     (armed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: bits sampled since the last flush, newest at the back.
    bit            hq[$];
    logic [PL-1:0] m_pat   = '0;
    logic [PL-1:0] m_mask  = '0;
    bit            m_ovl   = 1'b1;
    int            m_match = 0;
    int            m_cnt   = 0;
    int            m_armed = 0;

    function automatic bit window_hit();
        for (int i = 0; i < int'(PL); i++) begin
            if (!m_mask[int'(PL) - 1 - i] && (hq[i] != m_pat[int'(PL) - 1 - i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            hq.delete();
            m_pat   = '0;
            m_mask  = '0;
            m_ovl   = 1'b1;
            m_match = 0;
            m_cnt   = 0;
        end else begin
            m_match = 0;
            if (cfg_load) begin
                m_pat = cfg_pat;
                m_ovl = cfg_ovl;
`ifdef SEQ_DET_MASK_EN
                m_mask = cfg_mask;
`endif
                hq.delete();
            end else if (in_valid) begin
                hq.push_back(in_bit);
                if (hq.size() > int'(PL)) void'(hq.pop_front());
                if (hq.size() == int'(PL) && window_hit()) begin
                    m_match = 1;
                    if (!m_ovl) hq.delete();
                end
            end
            if (cnt_clr)                           m_cnt = 0;
            else if (m_match == 1 && m_cnt < CNT_MAX) m_cnt++;
        end
        m_armed = (hq.size() == int'(PL)) ? 1 : 0;
        #1;
        chk("model_match", int'(match), m_match);
        chk("model_cnt",   int'(match_cnt), m_cnt);
        chk("model_armed", int'(armed), m_armed);
    end

    task automatic cyc(input logic ld, input logic iv, input logic ib, input logic clr,
                       input logic [PL-1:0] pat, input logic ov, input logic [PL-1:0] msk);
        @(negedge clk);
        cfg_load = ld;
        in_valid = iv;
        in_bit   = ib;
        cnt_clr  = clr;
        cfg_pat  = pat;
        cfg_ovl  = ov;
        cfg_mask = msk;
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic b);
        cyc(1'b0, 1'b1, b, 1'b0, cfg_pat, cfg_ovl, cfg_mask);
    endtask

    logic [6:0] s2;
    logic [6:0] e2;
    logic [5:0] s3;
    logic [5:0] e3;
    int         e5[10] = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 3};

    initial begin
        rst_n    = 1'b0;
        cfg_load = 1'b0;
        cfg_pat  = '0;
        cfg_ovl  = 1'b1;
        cfg_mask = '0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        cnt_clr  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk("reset_match", int'(match), 0);
        chk("reset_cnt",   int'(match_cnt), 0);
        chk("reset_armed", int'(armed), 0);

        // Overlap: 1011 in 1011011 completes after bits 4 and 7.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b1, 4'b0000);
        s2 = 7'b1011011;
        e2 = 7'b0001001;
        for (int i = 6; i >= 0; i--) begin
            send(s2[i]);
            chk("ovl_match", int'(match), int'(e2[i]));
        end
        chk("ovl_cnt", int'(match_cnt), 2);

        // Non-overlap: 1010 in 101010 completes once, armed falls with the match.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b0, 4'b0000);
        s3 = 6'b101010;
        e3 = 6'b000100;
        for (int i = 5; i >= 0; i--) begin
            send(s3[i]);
            chk("novl_match", int'(match), int'(e3[i]));
            if (i == 2) chk("novl_armed", int'(armed), 0);
        end
        chk("novl_cnt", int'(match_cnt), 1);

        // Load together with a valid bit: bit dropped, history flushed, count kept.
        send(1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'b1010, 1'b1, 4'b0000);
        chk("load_match", int'(match), 0);
        chk("load_armed", int'(armed), 0);
        chk("load_cnt",   int'(match_cnt), 1);
        send(1'b1); send(1'b0); send(1'b1);
        chk("load_fill3_armed", int'(armed), 0);
        send(1'b0);
        chk("load_refill_match", int'(match), 1);
        chk("load_refill_armed", int'(armed), 1);

        // Reset mid-stream with three bits of history.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b1, 4'b0000);
        send(1'b1); send(1'b0); send(1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #2;
        chk("midrst_match", int'(match), 0);
        chk("midrst_cnt",   int'(match_cnt), 0);
        chk("midrst_armed", int'(armed), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b1);
        chk("midrst_bit4_match", int'(match), 0);
        chk("midrst_bit4_armed", int'(armed), 0);

        // Saturation with a 2-bit counter, then clear beating a coincident match.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            send(1'b1);
            chk("sat_cnt", int'(match_cnt), e5[i]);
        end
        cyc(1'b0, 1'b1, 1'b1, 1'b1, cfg_pat, cfg_ovl, cfg_mask);
        chk("clr_match", int'(match), 1);
        chk("clr_cnt",   int'(match_cnt), 0);

`ifdef SEQ_DET_MASK_EN
        // Only bit 3 is compared: every armed sample with a leading 1 matches.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 4'b0111);
        send(1'b1); send(1'b1); send(1'b1);
        chk("mask_fill_match", int'(match), 0);
        send(1'b1); chk("mask_m1", int'(match), 1);
        send(1'b0); chk("mask_m2", int'(match), 1);
        send(1'b0); chk("mask_m3", int'(match), 1);
        send(1'b0); chk("mask_m4", int'(match), 1);
        send(1'b0); chk("mask_m5", int'(match), 0);
`else
        // Mask input is ignored: 1101 is not 1000.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 4'b0111);
        send(1'b1); send(1'b1); send(1'b0); send(1'b1);
        chk("nomask_match", int'(match), 0);
        chk("nomask_armed", int'(armed), 1);
`endif

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst_n    = ($urandom_range(0, 299) != 0);
            cfg_load = ($urandom_range(0, 49) == 0);
            cfg_pat  = PL'($urandom);
            cfg_ovl  = 1'($urandom);
            cfg_mask = ($urandom_range(0, 1) == 0) ? '0 : PL'($urandom);
            in_valid = ($urandom_range(0, 9) < 7);
            in_bit   = 1'($urandom);
            cnt_clr  = ($urandom_range(0, 39) == 0);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        cfg_load = 1'b0;
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
